// File: rtl/mad_pkg.sv
// Shared types and encodings for the MAD pipeline controller.
package mad_pkg;

    typedef enum logic [2:0] {
        StRun,
        StStall,
        StRetWait,
        StDrain,
        StPushPc,
        StPushFl,
        StVector
    } state_e;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_VEC = 2'd2;
    localparam logic [1:0] PC_SEL_POP = 2'd3;

    // Counter must hold both the drain length and the return latency.
    function automatic int unsigned cnt_width(int unsigned num_stages, int unsigned ret_lat);
        int unsigned m;
        m = (num_stages > ret_lat) ? num_stages : ret_lat;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mad_down_counter.sv
// Loadable down-counter with zero flag, shared by the RET wait and interrupt drain.
module mad_down_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/mad_pipeline_ctrl.sv
// Central pipeline controller: stalls, branch flushes, RET/RTI waits and interrupt entry.
module mad_pipeline_ctrl
    import mad_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned BR_STAGE   = 2,
    parameter int unsigned LU_STAGE   = 1,
    parameter int unsigned RET_LAT    = 3
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Int,
    input  logic                  ld_use,
    input  logic                  br_taken,
    input  logic                  ret_dec,
    output logic                  pc_en,
    output logic [1:0]            pc_sel,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic                  push_pc,
    output logic                  push_flags,
    output logic                  save_tgt,
    output logic                  int_ack,
    output logic                  busy
);

    localparam int unsigned CNT_W = cnt_width(NUM_STAGES, RET_LAT);

    localparam logic [NUM_STAGES-1:0] BR_MASK = NUM_STAGES'((64'd1 << BR_STAGE) - 64'd1);
    localparam logic [NUM_STAGES-1:0] LU_HOLD = NUM_STAGES'((64'd1 << LU_STAGE) - 64'd1);
    localparam logic [NUM_STAGES-1:0] LU_BIT  = NUM_STAGES'(64'd1 << LU_STAGE);
    localparam logic [NUM_STAGES-1:0] IF_BIT  = NUM_STAGES'(1);

    if (BR_STAGE >= NUM_STAGES || LU_STAGE >= NUM_STAGES || RET_LAT < 1) begin : g_param_check
        $error("mad_pipeline_ctrl: illegal BR_STAGE/LU_STAGE/RET_LAT");
    end

    state_e           state_q, state_d;
    logic             save_tgt_q, save_tgt_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val, cnt_count;

    mad_down_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk      (Clk),
        .rst_n    (Rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        save_tgt_d  = save_tgt_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_dec     = 1'b0;
        pc_en       = 1'b1;
        pc_sel      = PC_SEL_SEQ;
        stage_en    = '1;
        stage_flush = '0;
        push_pc     = 1'b0;
        push_flags  = 1'b0;
        int_ack     = 1'b0;

        unique case (state_q)
            StRun: begin
                if (br_taken) begin
                    stage_flush = BR_MASK;
                    pc_sel      = PC_SEL_BR;
                end else if (ret_dec) begin
                    pc_en       = 1'b0;
                    stage_flush = IF_BIT;
                    cnt_load    = 1'b1;
                    cnt_val     = CNT_W'(RET_LAT - 1);
                    state_d     = StRetWait;
                end else if (ld_use) begin
                    pc_en       = 1'b0;
                    stage_en    = ~LU_HOLD;
                    stage_flush = LU_BIT;
                    state_d     = StStall;
                end else if (Int) begin
                    pc_en       = 1'b0;
                    stage_flush = IF_BIT;
                    cnt_load    = 1'b1;
                    cnt_val     = CNT_W'(NUM_STAGES - 1);
                    state_d     = StDrain;
                end
            end
            StStall: begin
                state_d = StRun;
            end
            StRetWait: begin
                pc_en       = 1'b0;
                stage_flush = IF_BIT;
                if (cnt_zero) begin
                    pc_sel  = PC_SEL_POP;
                    pc_en   = 1'b1;
                    state_d = StRun;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDrain: begin
                pc_en       = 1'b0;
                stage_flush = IF_BIT;
                cnt_dec     = !cnt_zero;
                // A branch resolving mid-drain means the return address is its target.
                if (br_taken) begin
                    stage_flush = BR_MASK | IF_BIT;
                    save_tgt_d  = 1'b1;
                end
                if (cnt_count <= CNT_W'(1)) begin
                    state_d = StPushPc;
                end
            end
            StPushPc: begin
                push_pc  = 1'b1;
                stage_en = '0;
                pc_en    = 1'b0;
                state_d  = StPushFl;
            end
            StPushFl: begin
                push_flags = 1'b1;
                stage_en   = '0;
                pc_en      = 1'b0;
                state_d    = StVector;
            end
            StVector: begin
                pc_sel     = PC_SEL_VEC;
                int_ack    = 1'b1;
                save_tgt_d = 1'b0;
                state_d    = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= StRun;
            save_tgt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            save_tgt_q <= save_tgt_d;
        end
    end

    assign save_tgt = save_tgt_q;
    assign busy     = (state_q != StRun);

endmodule
